// File: rtl/pox_exec_flag_if.sv
// Observation and status signals between the CPU-side monitors and the EXEC flag tracker.
interface pox_exec_flag_if;
    logic [15:0] pc;
    logic        mon_res;
    logic        er_wr;
    logic        irq;
    logic        dma_en;
    logic        exec_out;
    logic        sys_rst_out;
    logic [7:0]  viol_cnt;

    modport master (
        output pc, mon_res, er_wr, irq, dma_en,
        input  exec_out, sys_rst_out, viol_cnt
    );

    modport slave (
        input  pc, mon_res, er_wr, irq, dma_en,
        output exec_out, sys_rst_out, viol_cnt
    );
endinterface

// File: rtl/pox_exec_flag.sv
// Tracks atomic execution of the Executable Region and publishes the EXEC flag;
// any violation becomes a stretched reset request with a saturating violation count.
module pox_exec_flag #(
    parameter logic [15:0] ER_MIN   = 16'h8000,
    parameter logic [15:0] ER_MAX   = 16'h8FFE,
    parameter int          RST_HOLD = 4,
    parameter int          HOLD_W   = 3
) (
    input  logic         clk,
    input  logic         reset,
    pox_exec_flag_if.slave bus
);

    localparam logic [1:0] IDLE = 2'd0;
    localparam logic [1:0] RUN  = 2'd1;
    localparam logic [1:0] DONE = 2'd2;
    localparam logic [1:0] HOLD = 2'd3;

    localparam logic [HOLD_W-1:0] HOLD_LOAD = HOLD_W'(RST_HOLD - 1);

    logic [1:0]        state, state_nxt;
    logic [HOLD_W-1:0] cnt, cnt_nxt;
    logic [7:0]        viol_cnt;
    logic              in_er;
    logic              at_entry;
    logic              viol;

    assign in_er    = (bus.pc >= ER_MIN) && (bus.pc <= ER_MAX);
    assign at_entry = (bus.pc == ER_MIN);

    always_comb begin
        viol = 1'b0;
        case (state)
            IDLE:    viol = bus.mon_res || (in_er && !at_entry);
            RUN:     viol = bus.mon_res || bus.er_wr || bus.irq || bus.dma_en || !in_er;
            DONE:    viol = bus.mon_res || bus.er_wr || (in_er && !at_entry);
            default: viol = 1'b0;
        endcase
    end

    // Violation outranks every other transition; HOLD ignores everything but mon_res.
    always_comb begin
        state_nxt = state;
        cnt_nxt   = cnt;
        if (viol) begin
            state_nxt = HOLD;
            cnt_nxt   = HOLD_LOAD;
        end else begin
            case (state)
                IDLE: if (at_entry) state_nxt = RUN;
                RUN:  if (bus.pc == ER_MAX) state_nxt = DONE;
                DONE: if (at_entry) state_nxt = RUN;
                HOLD: begin
                    if (cnt != '0)
                        cnt_nxt = cnt - 1'b1;
                    else if (!bus.mon_res)
                        state_nxt = IDLE;
                end
                default: state_nxt = IDLE;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state    <= IDLE;
            cnt      <= '0;
            viol_cnt <= '0;
        end else begin
            state <= state_nxt;
            cnt   <= cnt_nxt;
            if (viol && viol_cnt != 8'hFF)
                viol_cnt <= viol_cnt + 8'd1;
        end
    end

    assign bus.exec_out    = (state == DONE);
    assign bus.sys_rst_out = (state == HOLD);
    assign bus.viol_cnt    = viol_cnt;

endmodule
